// File: rtl/slot_pkg.sv
// Shared types, widths and helpers for the slot machine game-flow logic.
package slot_pkg;

    localparam int SPRITE_W   = 3;
    localparam int REEL_IDX_W = 4;
    localparam int WIN_W      = 8;
    localparam int CREDIT_W   = 10;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = 10'd999;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LAUNCH,
        SPIN,
        WIN,
        TOTAL
    } spin_state_t;

    // Symbol index to sprite: indices 8..15 have no sprite and saturate to 7.
    function automatic logic [SPRITE_W-1:0] reel_to_sprite(input logic [REEL_IDX_W-1:0] idx);
        return idx[REEL_IDX_W-1] ? 3'd7 : idx[SPRITE_W-1:0];
    endfunction

    // The display has three digits, so balances above 999 are shown as 999.
    function automatic logic [CREDIT_W-1:0] clamp_credit(input logic [CREDIT_W-1:0] c);
        return (c > CREDIT_MAX) ? CREDIT_MAX : c;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for the raw start button plus a registered
// rising-edge pulse (one clock wide).
module btn_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_rise;

    // Synchronize the button and flag the cycle after it goes high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_meta   <= i_btn;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_rise   <= r_sync & ~r_sync_d;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/spin_sequencer.sv
// Game-flow controller: start press -> MCU result request -> reel launch ->
// win display -> total display. Owns the displayed credit value.
// Optional build macro SPIN_WATCHDOG_EN: bounds the wait for anim_done by
// SPIN_TIMEOUT_CYCLES and then continues as if the animation had finished.
module spin_sequencer
    import slot_pkg::*;
#(
    parameter int WIN_HOLD_CYCLES     = 25_000_000,
    parameter int FLASH_HALF_CYCLES   = 3_125_000,
`ifdef SPIN_WATCHDOG_EN
    parameter int SPIN_TIMEOUT_CYCLES = 250_000_000,
`endif
    parameter int REQ_TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_btn,
    input  logic                  result_valid,
    input  logic [REEL_IDX_W-1:0] reel1_idx,
    input  logic [REEL_IDX_W-1:0] reel2_idx,
    input  logic [REEL_IDX_W-1:0] reel3_idx,
    input  logic [WIN_W-1:0]      win_credits,
    input  logic                  is_win,
    input  logic [CREDIT_W-1:0]   total_credits,
    input  logic                  anim_done,
    output logic                  spin_req,
    output logic                  start_spin,
    output logic [SPRITE_W-1:0]   reel1_sprite,
    output logic [SPRITE_W-1:0]   reel2_sprite,
    output logic [SPRITE_W-1:0]   reel3_sprite,
    output logic [CREDIT_W-1:0]   disp_value,
    output logic                  win_flash,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [31:0] REQ_LAST   = 32'(REQ_TIMEOUT_CYCLES - 1);
    localparam logic [31:0] WIN_LAST   = 32'(WIN_HOLD_CYCLES - 1);
    localparam logic [31:0] FLASH_LAST = 32'(FLASH_HALF_CYCLES - 1);
`ifdef SPIN_WATCHDOG_EN
    localparam logic [31:0] SPIN_LAST  = 32'(SPIN_TIMEOUT_CYCLES - 1);
`endif

    spin_state_t r_state, w_next;

    logic [31:0] r_cnt;
    logic [31:0] r_fcnt;
    logic        w_start_rise;
    logic        w_take_result;
    logic        w_req_timeout;
    logic        w_spin_end;
    logic        w_cnt_en;
    logic        w_flash_tgl;

    logic [SPRITE_W-1:0] r_reel1, r_reel2, r_reel3;
    logic [WIN_W-1:0]    r_win_q;
    logic                r_is_win_q;
    logic [CREDIT_W-1:0] r_total_q;

    logic                r_spin_req, r_start_spin, r_win_flash, r_busy, r_done, r_err;
    logic [CREDIT_W-1:0] r_disp;

    btn_sync_edge u_btn (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_btn  (start_btn),
        .o_rise (w_start_rise)
    );

    // Next-state decode; also flags result capture and request timeout.
    always_comb begin
        w_next        = r_state;
        w_take_result = 1'b0;
        w_req_timeout = 1'b0;
        w_spin_end    = 1'b0;
        w_cnt_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_rise) w_next = REQ;
            end
            REQ: begin
                w_cnt_en = 1'b1;
                // A result on the timeout cycle still counts as a result.
                if (result_valid) begin
                    w_take_result = 1'b1;
                    w_next        = LAUNCH;
                end else if (r_cnt == REQ_LAST) begin
                    w_req_timeout = 1'b1;
                    w_next        = IDLE;
                end
            end
            LAUNCH: begin
                w_next = SPIN;
            end
            SPIN: begin
`ifdef SPIN_WATCHDOG_EN
                w_cnt_en   = 1'b1;
                w_spin_end = anim_done || (r_cnt == SPIN_LAST);
`else
                w_spin_end = anim_done;
`endif
                if (w_spin_end) w_next = r_is_win_q ? WIN : TOTAL;
            end
            WIN: begin
                w_cnt_en = 1'b1;
                if (r_cnt == WIN_LAST) w_next = TOTAL;
            end
            TOTAL: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_flash_tgl = (r_fcnt == FLASH_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Per-state cycle counter (cleared on every state change) and flash phase counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_next != r_state || !w_cnt_en) r_cnt <= '0;
            else                                r_cnt <= r_cnt + 32'd1;
            if (r_state != WIN || w_next != WIN || w_flash_tgl) r_fcnt <= '0;
            else                                                r_fcnt <= r_fcnt + 32'd1;
        end
    end

    // Capture the MCU result (sprites mapped, balance clamped) when accepted in REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reel1    <= '0;
            r_reel2    <= '0;
            r_reel3    <= '0;
            r_win_q    <= '0;
            r_is_win_q <= 1'b0;
            r_total_q  <= '0;
        end else if (w_take_result) begin
            r_reel1    <= reel_to_sprite(reel1_idx);
            r_reel2    <= reel_to_sprite(reel2_idx);
            r_reel3    <= reel_to_sprite(reel3_idx);
            r_win_q    <= win_credits;
            r_is_win_q <= is_win;
            r_total_q  <= clamp_credit(total_credits);
        end
    end

    // Registered outputs decoded from the state being entered, so they line up
    // with the state they describe. The display holds its old value while the
    // reels spin so the new balance is not revealed early. Flash starts lit on
    // WIN entry and inverts every FLASH_HALF_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spin_req   <= 1'b0;
            r_start_spin <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_win_flash  <= 1'b0;
            r_disp       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_spin_req   <= (w_next == REQ);
            r_start_spin <= (w_next == LAUNCH);
            r_busy       <= (w_next != IDLE);
            r_done       <= (w_next == TOTAL);
            if (w_next == WIN)
                r_win_flash <= (r_state != WIN) ? 1'b1 : (r_win_flash ^ w_flash_tgl);
            else
                r_win_flash <= 1'b0;
            case (w_next)
                WIN:         r_disp <= {{(CREDIT_W-WIN_W){1'b0}}, r_win_q};
                IDLE, TOTAL: r_disp <= r_total_q;
                default:     r_disp <= r_disp;
            endcase
            if (w_req_timeout)                       r_err <= 1'b1;
            else if (r_state == IDLE && w_start_rise) r_err <= 1'b0;
        end
    end

    assign spin_req     = r_spin_req;
    assign start_spin   = r_start_spin;
    assign reel1_sprite = r_reel1;
    assign reel2_sprite = r_reel2;
    assign reel3_sprite = r_reel3;
    assign disp_value   = r_disp;
    assign win_flash    = r_win_flash;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_spin_sequencer.sv
// Scoreboard bench for spin_sequencer: stimulus pushes expected sprites and
// final display values; a negedge monitor pops them on start_spin / done.
module tb_spin_sequencer;

    logic       clk = 1'b0;
    logic       reset, start_btn, result_valid, is_win, anim_done;
    logic [3:0] reel1_idx, reel2_idx, reel3_idx;
    logic [7:0] win_credits;
    logic [9:0] total_credits;
    logic       spin_req, start_spin, win_flash, busy, done, err;
    logic [2:0] reel1_sprite, reel2_sprite, reel3_sprite;
    logic [9:0] disp_value;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_launch_q[$];
    logic [9:0] exp_done_q[$];
    logic [8:0] mon_launch;
    logic [9:0] mon_done;

    always #5 clk = ~clk;

    spin_sequencer #(
        .WIN_HOLD_CYCLES     (20),
        .FLASH_HALF_CYCLES   (4),
`ifdef SPIN_WATCHDOG_EN
        .SPIN_TIMEOUT_CYCLES (50),
`endif
        .REQ_TIMEOUT_CYCLES  (30)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_btn     (start_btn),
        .result_valid  (result_valid),
        .reel1_idx     (reel1_idx),
        .reel2_idx     (reel2_idx),
        .reel3_idx     (reel3_idx),
        .win_credits   (win_credits),
        .is_win        (is_win),
        .total_credits (total_credits),
        .anim_done     (anim_done),
        .spin_req      (spin_req),
        .start_spin    (start_spin),
        .reel1_sprite  (reel1_sprite),
        .reel2_sprite  (reel2_sprite),
        .reel3_sprite  (reel3_sprite),
        .disp_value    (disp_value),
        .win_flash     (win_flash),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every launch and every completion must match a queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (start_spin === 1'b1) begin
                if (exp_launch_q.size() == 0) check("unexpected_start_spin", 32'(start_spin), 0);
                else begin
                    mon_launch = exp_launch_q.pop_front();
                    check("sprites", {23'd0, reel1_sprite, reel2_sprite, reel3_sprite}, {23'd0, mon_launch});
                end
            end
            if (done === 1'b1) begin
                if (exp_done_q.size() == 0) check("unexpected_done", 32'(done), 0);
                else begin
                    mon_done = exp_done_q.pop_front();
                    check("done_disp", 32'(disp_value), 32'(mon_done));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press start and wait (bounded) for the registered spin request.
    task automatic press();
        int lat;
        lat = 0;
        start_btn = 1'b1;
        while (lat < 10 && spin_req !== 1'b1) begin
            tick(1);
            lat++;
        end
        check("spin_req_up", 32'(spin_req), 1);
        check("btn_to_req_latency", lat, 4);
        start_btn = 1'b0;
    endtask

    // One-cycle result pulse; leaves the bench in the LAUNCH cycle.
    task automatic result(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
                          input logic [7:0] w, input logic iw, input logic [9:0] tot,
                          input logic [8:0] exp_spr);
        reel1_idx = r1; reel2_idx = r2; reel3_idx = r3;
        win_credits = w; is_win = iw; total_credits = tot;
        result_valid = 1'b1;
        exp_launch_q.push_back(exp_spr);
        tick(1);
        result_valid = 1'b0;
        check("start_spin_at_N+1", 32'(start_spin), 1);
    endtask

    task automatic anim();
        anim_done = 1'b1;
        tick(1);
        anim_done = 1'b0;
    endtask

    initial begin : hard_timeout
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start_btn = 0; result_valid = 0; is_win = 0; anim_done = 0;
        reel1_idx = 0; reel2_idx = 0; reel3_idx = 0; win_credits = 0; total_credits = 0;
        tick(3);
        check("rst_spin_req", 32'(spin_req), 0);
        check("rst_start_spin", 32'(start_spin), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_flash", 32'(win_flash), 0);
        check("rst_disp", 32'(disp_value), 0);
        check("rst_sprites", {23'd0, reel1_sprite, reel2_sprite, reel3_sprite}, 0);
        reset = 1'b0;
        tick(2);

        // Loss spin: reel 9 saturates to sprite 7.
        press();
        check("loss_busy", 32'(busy), 1);
        tick(2);
        result(4'd2, 4'd5, 4'd9, 8'd0, 1'b0, 10'd37, {3'd2, 3'd5, 3'd7});
        tick(1);
        check("start_spin_one_cycle", 32'(start_spin), 0);
        tick(3);
        exp_done_q.push_back(10'd37);
        anim();
        check("loss_done_M+1", 32'(done), 1);
        check("loss_disp", 32'(disp_value), 37);
        tick(1);
        check("loss_done_pulse", 32'(done), 0);
        check("loss_idle", 32'(busy), 0);

        // Win spin: 50 shown for 20 cycles, flash period 8, then 120 with done.
        press();
        result(4'd1, 4'd0, 4'd15, 8'd50, 1'b1, 10'd120, {3'd1, 3'd0, 3'd7});
        tick(2);
        exp_done_q.push_back(10'd120);
        anim();
        for (int k = 0; k < 20; k++) begin
            check("win_disp", 32'(disp_value), 50);
            check("win_flash", 32'(win_flash), ((k / 4) % 2 == 0) ? 1 : 0);
            check("win_no_done", 32'(done), 0);
            tick(1);
        end
        check("win_done", 32'(done), 1);
        check("win_total_disp", 32'(disp_value), 120);
        check("win_flash_off", 32'(win_flash), 0);
        tick(1);
        check("win_idle", 32'(busy), 0);

        // No MCU response: REQ lasts exactly 30 cycles, then err and IDLE.
        press();
        tick(29);
        check("req_still", 32'(spin_req), 1);
        check("req_no_err", 32'(err), 0);
        tick(1);
        check("timeout_req_drop", 32'(spin_req), 0);
        check("timeout_err", 32'(err), 1);
        check("timeout_idle", 32'(busy), 0);
        check("timeout_disp_keep", 32'(disp_value), 120);
        tick(3);
        press();
        check("err_cleared", 32'(err), 0);
        result(4'd3, 4'd4, 4'd8, 8'd0, 1'b0, 10'd1000, {3'd3, 3'd4, 3'd7});
        tick(2);
        exp_done_q.push_back(10'd999);
        anim();
        check("clamp_done", 32'(done), 1);
        check("clamp_disp", 32'(disp_value), 999);
        tick(2);

        // Ignored events: result and anim_done in IDLE, start press in SPIN.
        reel1_idx = 4'd1; total_credits = 10'd5; result_valid = 1'b1;
        tick(1);
        result_valid = 1'b0;
        tick(1);
        check("idle_result_busy", 32'(busy), 0);
        check("idle_result_disp", 32'(disp_value), 999);
        anim();
        tick(1);
        check("idle_anim_busy", 32'(busy), 0);
        press();
        result(4'd6, 4'd7, 4'd12, 8'd0, 1'b0, 10'd200, {3'd6, 3'd7, 3'd7});
        tick(2);
        start_btn = 1'b1;
        tick(6);
        start_btn = 1'b0;
        tick(4);
        check("spin_press_busy", 32'(busy), 1);
        check("spin_press_no_req", 32'(spin_req), 0);
        exp_done_q.push_back(10'd200);
        anim();
        check("ignored_done", 32'(done), 1);
        check("ignored_disp", 32'(disp_value), 200);
        tick(2);

        // Reset in WIN: outputs clear at once, no done afterwards.
        press();
        result(4'd7, 4'd7, 4'd7, 8'd9, 1'b1, 10'd300, {3'd7, 3'd7, 3'd7});
        tick(2);
        anim();
        tick(5);
        check("pre_rst_disp", 32'(disp_value), 9);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_disp", 32'(disp_value), 0);
        check("midrst_flash", 32'(win_flash), 0);
        check("midrst_sprites", {23'd0, reel1_sprite, reel2_sprite, reel3_sprite}, 0);
        tick(3);
        reset = 1'b0;
        tick(30);
        check("postrst_idle", 32'(busy), 0);
        check("postrst_disp", 32'(disp_value), 0);

        // Withheld anim_done.
        press();
        result(4'd0, 4'd1, 4'd2, 8'd0, 1'b0, 10'd444, {3'd0, 3'd1, 3'd2});
        tick(1);
`ifdef SPIN_WATCHDOG_EN
        tick(49);
        check("wd_still_spin", 32'(busy), 1);
        check("wd_no_done", 32'(done), 0);
        exp_done_q.push_back(10'd444);
        tick(1);
        check("wd_done", 32'(done), 1);
        check("wd_no_err", 32'(err), 0);
`else
        tick(60);
        check("nowd_still_spin", 32'(busy), 1);
        check("nowd_no_done", 32'(done), 0);
        exp_done_q.push_back(10'd444);
        anim();
        check("nowd_done", 32'(done), 1);
`endif
        tick(2);

        check("launch_q_empty", exp_launch_q.size(), 0);
        check("done_q_empty", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spin_sequencer.md
# spin_sequencer

Central game-flow controller for the slot machine FPGA. Sits between `spi_data_extract` (MCU results), `memory_controller` (reel animation) and the seven-segment driver. Sequences one spin end to end: start press → MCU result request → reel animation launch → win display → total display. Owns the displayed credit value and the `done` indication.

## Interface
Parameters:
- `WIN_HOLD_CYCLES`, default 25_000_000: cycles the win amount is shown (1 s at the 25 MHz pixel clock).
- `FLASH_HALF_CYCLES`, default 3_125_000: half-period of `win_flash` toggling.
- `REQ_TIMEOUT_CYCLES`, default 50_000_000: maximum wait for the MCU result.
- `SPIN_TIMEOUT_CYCLES`, default 250_000_000: watchdog limit on the animation; present only with the watchdog macro.

Ports:
- `clk` in 1: system/pixel clock.
- `reset` in 1: asynchronous, active-high reset.
- `start_btn` in 1: raw, asynchronous start button.
- `result_valid` in 1: one-cycle pulse; the reel/credit inputs are valid on this cycle.
- `reel1_idx`, `reel2_idx`, `reel3_idx` in 4 each: final symbol indices.
- `win_credits` in 8: credits won on this spin.
- `is_win` in 1: spin is a win.
- `total_credits` in 10: new credit balance.
- `anim_done` in 1: one-cycle pulse from `memory_controller`; all reels have stopped.
- `spin_req` out 1: level request to the MCU for a result.
- `start_spin` out 1: one-cycle launch pulse to `memory_controller`.
- `reel1_sprite`, `reel2_sprite`, `reel3_sprite` out 3 each: latched final sprites.
- `disp_value` out 10: value driven to the seven-segment driver.
- `win_flash` out 1: blink enable for the display.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a spin completes.
- `err` out 1: sticky request-timeout flag; cleared by the next accepted start.

## Operation
- `start_btn` passes through a 2-flop synchronizer and rising-edge detect. The resulting `start_rise` is the only start event.
- State machine, one-hot-encodable enum:
  - IDLE: `disp_value` = `total_q`. On `start_rise`, clear `err` and go to REQ.
  - REQ: `spin_req` = 1 and count cycles.
    - If `result_valid` arrives: latch reels, `win_q` and `total_q`, then go to LAUNCH.
    - If the count reaches `REQ_TIMEOUT_CYCLES` with no result: set `err` and go to IDLE.
    - If `result_valid` and the timeout occur on the same cycle, the result wins.
  - LAUNCH: exactly one cycle. `start_spin` = 1, then go to SPIN.
  - SPIN: wait for `anim_done`, then go to WIN if `is_win_q`, otherwise to TOTAL.
  - WIN: `disp_value` = `win_q` and `win_flash` toggles every `FLASH_HALF_CYCLES`. After `WIN_HOLD_CYCLES`, go to TOTAL.
  - TOTAL: one cycle. `disp_value` = `total_q`, `done` = 1, then go to IDLE.
- Reel mapping: sprite = idx[2:0] when idx < 8; any idx ≥ 8 saturates to 3'd7.
- `total_credits` above 999 is clamped to 999 at latch.
- `win_q` is zero-extended to 10 bits for `disp_value`.
- `start_rise` outside IDLE is ignored; there is no queuing.
- `result_valid` outside REQ is dropped.
- `anim_done` outside SPIN is ignored.
- All counters clear on every state entry.

## Timing
- Reset values: state IDLE; every output 0; `disp_value` = 0; `total_q` = 0; reel latches = 0.
- Reset mid-spin returns immediately to IDLE and discards any pending result.
- Button to REQ: the `start_btn` edge, plus 2 sync cycles, plus 1 edge cycle, plus 1 cycle for registered `spin_req`.
- `result_valid` at cycle N: sprites are valid from N+1, and `start_spin` is high exactly at N+1.
- `anim_done` at cycle M: TOTAL (with `done`) is at M+1 for a loss and at M+1+`WIN_HOLD_CYCLES` for a win.
- All outputs are registered.

## Configuration
- `SPIN_WATCHDOG_EN` defined: SPIN counts cycles. If `anim_done` has not arrived within `SPIN_TIMEOUT_CYCLES`, the block proceeds exactly as if `anim_done` had arrived, and it does not set `err`.
- Not defined: SPIN waits indefinitely, and the parameter and its counter are absent.

## Structure
- Package `slot_pkg` holds:
  - `spin_state_t` enum
  - `SPRITE_W` = 3, `REEL_IDX_W` = 4, `WIN_W` = 8, `CREDIT_W` = 10
  - `CREDIT_MAX` = 999
- Sub-module `btn_sync_edge` (2-flop sync plus rising-edge pulse) is instantiated once.

## Test plan
Use small parameters: `WIN_HOLD_CYCLES`=20, `FLASH_HALF_CYCLES`=4, `REQ_TIMEOUT_CYCLES`=30, `SPIN_TIMEOUT_CYCLES`=50.

- Loss spin: press start; `result_valid` with reels 2/5/9, `is_win`=0, total=37 → `start_spin` pulses once; sprites read 2/5/7; after `anim_done`, `done` pulses the next cycle; `disp_value`=37.
- Win spin: `win_credits`=50, total=120 → `disp_value`=50 for 20 cycles with `win_flash` toggling every 4 cycles, then 120 with `done`.
- No MCU response: press start, withhold `result_valid` → `err`=1 and IDLE after 30 cycles; the next start clears `err`.
- Ignored events: start press during SPIN, and `result_valid` in IDLE → no state change and no `start_spin`. Also `total_credits`=1000 → `disp_value`=999.
- Reset during WIN → all outputs 0 immediately; no `done` pulse.
- With `SPIN_WATCHDOG_EN`, withhold `anim_done` → TOTAL/WIN entered after 50 cycles. Without the macro → the block stays in SPIN.
